// File: rtl/seq_mul_acc.sv
// -----------------------------------------------------------------------------
// seq_mul_acc
//
// Sequential shift-add multiply-accumulate: out = a * b + acc, two's
// complement, modulo 2^(2N). One radix-2 iteration is performed per prescaler
// tick (every CLK_DIV_MULTIPLIER clocks), trading latency for area.
// Responds to a start/done strobe handshake.
//
// Parameters:
//   N                  operand base width; data ports are 2N bits
//   CLK_DIV_MULTIPLIER clocks per shift-add iteration (>= 1)
//
// Ports:
//   clk_i              clock, rising edge
//   rst_i              synchronous active-high reset (aborts any operation)
//   MUL_Start_STRB_i   start request, sampled only while idle
//   MUL_Done_STRB_o    one-cycle pulse, out_o valid in the same cycle
//   busy_o             high from accept until the cycle after the done pulse
//   a_i, b_i, acc_i    multiplicand, multiplier, addend (latched at accept)
//   out_o              result register, held until the next done
//
// Optional feature macro: SEQ_MUL_ACC_EARLY_EXIT_EN
//   When defined, the operation finishes as soon as the remaining multiplier
//   bits are all zero, giving operand-dependent latency with identical result.
// -----------------------------------------------------------------------------
module seq_mul_acc #(
    parameter int N                  = 41,
    parameter int CLK_DIV_MULTIPLIER = 50
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  MUL_Start_STRB_i,
    output logic                  MUL_Done_STRB_o,
    output logic                  busy_o,
    input  logic signed [2*N-1:0] a_i,
    input  logic signed [2*N-1:0] b_i,
    input  logic signed [2*N-1:0] acc_i,
    output logic signed [2*N-1:0] out_o
);

    localparam int W  = 2 * N;
    localparam int PW = (CLK_DIV_MULTIPLIER > 1) ? $clog2(CLK_DIV_MULTIPLIER) : 1;
    localparam int CW = $clog2(W + 1);

`ifdef SEQ_MUL_ACC_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    // The truncated unsigned shift-add product equals the two's-complement
    // product mod 2^W, so the working registers are deliberately unsigned.
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  p_q;
    logic [CW-1:0] iter_cnt;
    logic [PW-1:0] presc;

    // Plain W-bit add; the carry out is discarded so overflow wraps.
    function automatic logic [W-1:0] wrap_add(input logic [W-1:0] x,
                                              input logic [W-1:0] y);
        return x + y;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= S_IDLE;
            MUL_Done_STRB_o <= 1'b0;
            busy_o          <= 1'b0;
            out_o           <= '0;
            a_q             <= '0;
            b_q             <= '0;
            p_q             <= '0;
            iter_cnt        <= '0;
            presc           <= '0;
        end else begin
            MUL_Done_STRB_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (MUL_Start_STRB_i) begin
                        a_q      <= a_i;
                        b_q      <= b_i;
                        p_q      <= acc_i;
                        iter_cnt <= '0;
                        presc    <= '0;
                        busy_o   <= 1'b1;
                        state    <= S_RUN;
                    end else begin
                        // Also clears busy the cycle after a done pulse.
                        busy_o <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (EARLY_EXIT && (b_q == '0)) begin
                        // No set multiplier bits remain: P is already final.
                        out_o           <= $signed(p_q);
                        MUL_Done_STRB_o <= 1'b1;
                        state           <= S_IDLE;
                    end else if (presc == PW'(CLK_DIV_MULTIPLIER - 1)) begin
                        presc <= '0;
                        if (b_q[0]) begin
                            p_q <= wrap_add(p_q, a_q);
                        end
                        a_q      <= a_q << 1;
                        b_q      <= b_q >> 1;
                        iter_cnt <= iter_cnt + CW'(1);
                        if (iter_cnt == CW'(W - 1)) begin
                            state <= S_DONE;
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end

                S_DONE: begin
                    // busy_o stays high through the pulse cycle; IDLE drops it.
                    out_o           <= $signed(p_q);
                    MUL_Done_STRB_o <= 1'b1;
                    state           <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
